// File: rtl/bus_irq_rr_scheduler_pkg.sv
// rtl/bus_irq_rr_scheduler_pkg.sv - shared constants and FSM encoding for the hub IRQ scheduler
// Contents: default bus count, grant id width, IRQ collector word width and
// the scheduler state encoding shared by the hub arbiters.
package mopshub_irq_pkg;

  localparam int N_BUSES_DEF = 16;
  localparam int ID_W_DEF    = 5;
  localparam int IRQ_W       = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    BUSY  = 2'd2
  } sched_state_t;

endpackage

// File: rtl/bus_irq_rr_scheduler_if.sv
// rtl/bus_irq_rr_scheduler_if.sv - grant handshake between scheduler and message handler
// Signals: grant_valid/grant_id (scheduler -> handler), grant_ready/done
// (handler -> scheduler). master = scheduler side, slave = handler side.
interface bus_irq_rr_scheduler_if
  import mopshub_irq_pkg::*;
#(
  parameter int ID_W = ID_W_DEF
) ();

  logic            grant_valid;
  logic [ID_W-1:0] grant_id;
  logic            grant_ready;
  logic            done;

  modport master (
    output grant_valid,
    output grant_id,
    input  grant_ready,
    input  done
  );

  modport slave (
    input  grant_valid,
    input  grant_id,
    output grant_ready,
    output done
  );

endinterface

// File: rtl/bus_irq_rr_scheduler_rr_priority_pick.sv
// rtl/bus_irq_rr_scheduler_rr_priority_pick.sv - combinational round-robin first-set finder
// Ports: req (request vector), ptr (search start), found (any request set),
// index (first set bit at or after ptr, wrapping from N-1 to 0).
module rr_priority_pick
  import mopshub_irq_pkg::*;
#(
  parameter int N     = N_BUSES_DEF,
  parameter int IDX_W = ID_W_DEF,
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] index
);

  localparam int SUM_W = PTR_W + 1;

  logic [N-1:0]     rot;
  logic [PTR_W-1:0] off;
  logic [SUM_W-1:0] sum;
  logic [SUM_W-1:0] wrapped;

  // Rotate so that req[ptr] lands at bit 0; the lowest set bit is the winner.
  assign rot = N'({req, req} >> ptr);

  always_comb begin
    found = 1'b0;
    off   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        off   = PTR_W'(i);
      end
    end
  end

  assign sum     = {1'b0, ptr} + {1'b0, off};
  assign wrapped = (sum >= SUM_W'(N)) ? (sum - SUM_W'(N)) : sum;
  assign index   = IDX_W'(wrapped);

endmodule

// File: rtl/bus_irq_rr_scheduler.sv
// rtl/bus_irq_rr_scheduler.sv - round-robin scheduler of per-bus IRQ requests onto one handler
// Ports: clk, rst (async active-low), irq_in (32-bit request word, bits
// above N_BUSES ignored), gnt (grant handshake, master side), busy (grant
// accepted and running), pending (sticky request bits), timeout_err (one-cycle
// pulse on watchdog release).
module bus_irq_rr_scheduler
  import mopshub_irq_pkg::*;
#(
  parameter int N_BUSES        = N_BUSES_DEF,
  parameter int ID_W           = ID_W_DEF,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [IRQ_W-1:0]            irq_in,
  bus_irq_rr_scheduler_if.master      gnt,
  output logic                        busy,
  output logic [IRQ_W-1:0]            pending,
  output logic                        timeout_err
);

  localparam int PTR_W = (N_BUSES > 1) ? $clog2(N_BUSES) : 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

  sched_state_t     state;
  logic [N_BUSES-1:0] pend_q;
  logic [PTR_W-1:0] ptr;
  logic [WD_W-1:0]  wd;
  logic [WD_W-1:0]  wd_next;
  logic             expire;
  logic             release_now;
  logic [N_BUSES-1:0] clr_mask;
  logic [ID_W-1:0]  id_plus;
  logic [PTR_W-1:0] ptr_next;
  logic             pick_found;
  logic [ID_W-1:0]  pick_idx;

  generate
    if (N_BUSES < IRQ_W) begin : g_hi_bits
      logic unused_irq_hi;
      assign unused_irq_hi = |irq_in[IRQ_W-1:N_BUSES];
    end
  endgenerate

  rr_priority_pick #(
    .N     (N_BUSES),
    .IDX_W (ID_W)
  ) u_pick (
    .req   (pend_q),
    .ptr   (ptr),
    .found (pick_found),
    .index (pick_idx)
  );

  // wd counts completed BUSY cycles; release on the edge where it would reach the limit.
  assign wd_next     = wd + 1'b1;
  assign expire      = (wd_next == WD_W'(TIMEOUT_CYCLES));
  assign release_now = (state == BUSY) && (gnt.done || expire);
  assign clr_mask    = release_now ? (N_BUSES'(1) << gnt.grant_id) : '0;
  assign id_plus     = gnt.grant_id + 1'b1;
  assign ptr_next    = (gnt.grant_id == ID_W'(N_BUSES - 1)) ? '0 : PTR_W'(id_plus);
  assign pending     = IRQ_W'(pend_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      pend_q          <= '0;
      ptr             <= '0;
      wd              <= '0;
      busy            <= 1'b0;
      timeout_err     <= 1'b0;
      gnt.grant_valid <= 1'b0;
      gnt.grant_id    <= '0;
    end else begin
      // A new request on the releasing bus survives the clear.
      pend_q      <= (pend_q & ~clr_mask) | irq_in[N_BUSES-1:0];
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_found) begin
            gnt.grant_id    <= pick_idx;
            gnt.grant_valid <= 1'b1;
            state           <= OFFER;
          end
        end
        OFFER: begin
          if (gnt.grant_ready) begin
            gnt.grant_valid <= 1'b0;
            busy            <= 1'b1;
            wd              <= '0;
            state           <= BUSY;
          end
        end
        BUSY: begin
          if (release_now) begin
            busy        <= 1'b0;
            ptr         <= ptr_next;
            timeout_err <= !gnt.done;
            state       <= IDLE;
          end else begin
            wd <= wd_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_irq_rr_scheduler.sv
// tb/tb_bus_irq_rr_scheduler.sv - scoreboard bench for bus_irq_rr_scheduler
module tb_bus_irq_rr_scheduler;

  localparam int NB  = 16;
  localparam int IW  = 5;
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] irq_in = '0;
  logic        busy;
  logic [31:0] pending;
  logic        timeout_err;

  bus_irq_rr_scheduler_if #(.ID_W(IW)) gif ();

  always #5 clk = ~clk;

  bus_irq_rr_scheduler #(
    .N_BUSES        (NB),
    .ID_W           (IW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .irq_in      (irq_in),
    .gnt         (gif),
    .busy        (busy),
    .pending     (pending),
    .timeout_err (timeout_err)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  // ---------------- reference model (transaction-level rules) ----------------
  typedef enum {PH_IDLE, PH_OFFER, PH_BUSY} ph_t;
  ph_t         m_ph = PH_IDLE;
  bit [NB-1:0] m_pend = '0;
  bit [NB-1:0] m_clr;
  int          m_ptr = 0;
  int          m_id = 0;
  int          m_age = 0;
  int          cyc = 0;
  int          exp_grant_q[$];
  int          exp_tmo_q[$];

  function automatic int rr_winner(input bit [NB-1:0] p, input int start);
    for (int off = 0; off < NB; off++) begin
      int b = (start + off) % NB;
      if (((p >> b) & 1) != 0) return b;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_ph   = PH_IDLE;
      m_pend = '0;
      m_ptr  = 0;
      m_id   = 0;
      m_age  = 0;
      exp_grant_q.delete();
      exp_tmo_q.delete();
    end else begin
      cyc++;
      m_clr = '0;
      case (m_ph)
        PH_IDLE: begin
          if (m_pend != 0) begin
            m_id = rr_winner(m_pend, m_ptr);
            exp_grant_q.push_back(m_id);
            m_ph = PH_OFFER;
          end
        end
        PH_OFFER: begin
          if (gif.grant_ready) begin
            m_ph  = PH_BUSY;
            m_age = 0;
          end
        end
        default: begin
          m_age++;
          if (gif.done || m_age == TMO) begin
            if (!gif.done) exp_tmo_q.push_back(cyc);
            m_clr = NB'(1) << m_id;
            m_ptr = (m_id + 1) % NB;
            m_ph  = PH_IDLE;
          end
        end
      endcase
      m_pend = (m_pend & ~m_clr) | irq_in[NB-1:0];
    end
  end

  // ---------------- monitor ----------------
  bit prev_gv = 1'b0;

  always @(negedge clk) begin
    chk("grant_valid", {31'b0, gif.grant_valid}, {31'b0, m_ph == PH_OFFER});
    chk("busy", {31'b0, busy}, {31'b0, m_ph == PH_BUSY});
    chk("pending", pending, {16'h0, m_pend});
    if (gif.grant_valid && !prev_gv) begin
      if (exp_grant_q.size() == 0) fail_now("unexpected_offer");
      else chk("grant_id", {27'b0, gif.grant_id}, exp_grant_q.pop_front());
    end
    if (timeout_err) begin
      if (exp_tmo_q.size() == 0) fail_now("unexpected_timeout");
      else chk("timeout_cycle", cyc, exp_tmo_q.pop_front());
    end
    prev_gv = gif.grant_valid;
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic [31:0] i, input logic r, input logic d);
    irq_in          = i;
    gif.grant_ready = r;
    gif.done        = d;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step(32'h0, 1'b0, 1'b0);
    step(32'h0, 1'b0, 1'b0);
    rst = 1'b1;
  endtask

  int rr_got[6];
  int rr_n;
  bit rr_pv;
  int exp_rr[6] = '{0, 1, 15, 0, 1, 15};
  int pct_tab[5] = '{0, 5, 30, 60, 100};

  initial begin
    gif.grant_ready = 1'b0;
    gif.done        = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // reset state and quiet idle
    chk("rst_grant_valid", {31'b0, gif.grant_valid}, 32'h0);
    chk("rst_grant_id", {27'b0, gif.grant_id}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_pending", pending, 32'h0);
    chk("rst_timeout", {31'b0, timeout_err}, 32'h0);
    repeat (50) step(32'h0, 1'b0, 1'b0);
    chk("idle_grant_valid", {31'b0, gif.grant_valid}, 32'h0);

    // single request on bus 5
    step(32'h0000_0020, 1'b0, 1'b0);
    chk("single_pending", pending, 32'h20);
    chk("single_no_offer_yet", {31'b0, gif.grant_valid}, 32'h0);
    step(32'h0, 1'b0, 1'b0);
    chk("single_offer", {31'b0, gif.grant_valid}, 32'h1);
    chk("single_id", {27'b0, gif.grant_id}, 32'd5);
    step(32'h0, 1'b1, 1'b0);
    chk("single_busy", {31'b0, busy}, 32'h1);
    step(32'h0, 1'b0, 1'b1);
    chk("single_done_pending", pending, 32'h0);
    chk("single_done_busy", {31'b0, busy}, 32'h0);
    // ptr now 6: buses 4 and 7 pending, 7 must win
    step(32'h0000_0090, 1'b0, 1'b0);
    step(32'h0, 1'b0, 1'b0);
    chk("ptr_advance_id", {27'b0, gif.grant_id}, 32'd7);
    step(32'h0, 1'b1, 1'b0);
    step(32'h0, 1'b0, 1'b1);
    step(32'h0, 1'b0, 1'b0);
    chk("ptr_wrap_id", {27'b0, gif.grant_id}, 32'd4);
    step(32'h0, 1'b1, 1'b0);
    step(32'h0, 1'b0, 1'b1);

    // round-robin fairness from ptr=0
    do_reset();
    rr_n  = 0;
    rr_pv = 1'b0;
    for (int i = 0; i < 6; i++) rr_got[i] = -1;
    for (int i = 0; i < 20; i++) begin
      step(32'h0000_8003, 1'b1, 1'b1);
      if (gif.grant_valid && !rr_pv && rr_n < 6) begin
        rr_got[rr_n] = int'(gif.grant_id);
        rr_n++;
      end
      rr_pv = gif.grant_valid;
    end
    chk("rr_count", rr_n, 6);
    for (int i = 0; i < 6; i++) chk($sformatf("rr_order_%0d", i), rr_got[i], exp_rr[i]);
    repeat (12) step(32'h0, 1'b1, 1'b1);
    chk("rr_drained", pending, 32'h0);

    // set and clear of bus 3 on the same edge
    step(32'h0000_0008, 1'b0, 1'b0);
    step(32'h0, 1'b0, 1'b0);
    chk("setclr_offer_id", {27'b0, gif.grant_id}, 32'd3);
    step(32'h0, 1'b1, 1'b0);
    step(32'h0000_0008, 1'b0, 1'b1);
    chk("setclr_pending_kept", pending, 32'h8);
    chk("setclr_busy", {31'b0, busy}, 32'h0);
    step(32'h0, 1'b0, 1'b0);
    chk("setclr_reoffer", {31'b0, gif.grant_valid}, 32'h1);
    chk("setclr_reoffer_id", {27'b0, gif.grant_id}, 32'd3);
    step(32'h0, 1'b1, 1'b0);
    step(32'h0, 1'b0, 1'b1);

    // watchdog expiry on bus 2
    step(32'h0000_0004, 1'b0, 1'b0);
    step(32'h0, 1'b0, 1'b0);
    step(32'h0, 1'b1, 1'b0);
    for (int i = 0; i < TMO - 1; i++) begin
      step(32'h0, 1'b0, 1'b0);
      chk("wd_still_busy", {31'b0, busy}, 32'h1);
      chk("wd_no_early_timeout", {31'b0, timeout_err}, 32'h0);
    end
    step(32'h0, 1'b0, 1'b0);
    chk("wd_timeout_pulse", {31'b0, timeout_err}, 32'h1);
    chk("wd_busy_released", {31'b0, busy}, 32'h0);
    chk("wd_pending_cleared", pending, 32'h0);
    step(32'h0, 1'b0, 1'b0);
    chk("wd_single_pulse", {31'b0, timeout_err}, 32'h0);

    // done on the expiry edge wins
    step(32'h0000_0004, 1'b0, 1'b0);
    step(32'h0, 1'b0, 1'b0);
    step(32'h0, 1'b1, 1'b0);
    repeat (TMO - 1) step(32'h0, 1'b0, 1'b0);
    step(32'h0, 1'b0, 1'b1);
    chk("done_vs_wd_no_timeout", {31'b0, timeout_err}, 32'h0);
    chk("done_vs_wd_busy", {31'b0, busy}, 32'h0);
    step(32'h0, 1'b0, 1'b0);
    chk("done_vs_wd_after", {31'b0, timeout_err}, 32'h0);

    // asynchronous reset mid-grant
    step(32'h0000_0041, 1'b0, 1'b0);
    step(32'h0, 1'b0, 1'b0);
    step(32'h0, 1'b1, 1'b0);
    chk("mid_busy", {31'b0, busy}, 32'h1);
    #2 rst = 1'b0;
    #1;
    chk("async_grant_valid", {31'b0, gif.grant_valid}, 32'h0);
    chk("async_grant_id", {27'b0, gif.grant_id}, 32'h0);
    chk("async_busy", {31'b0, busy}, 32'h0);
    chk("async_pending", pending, 32'h0);
    chk("async_timeout", {31'b0, timeout_err}, 32'h0);
    gif.grant_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // bits above N_BUSES are ignored
    repeat (3) step(32'h0010_0000, 1'b0, 1'b0);
    chk("hi_bit_pending", pending, 32'h0);
    chk("hi_bit_no_grant", {31'b0, gif.grant_valid}, 32'h0);

    // randomized traffic
    for (int blk = 0; blk < 10; blk++) begin
      int pct = pct_tab[blk % 5];
      for (int c = 0; c < 200; c++) begin
        logic [31:0] r_irq;
        r_irq = '0;
        if ($urandom_range(0, 99) < 30) r_irq = 32'h1 << $urandom_range(0, 31);
        if ($urandom_range(0, 99) < 5) r_irq = r_irq | ($urandom & $urandom);
        step(r_irq, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 99) < pct));
      end
    end
    repeat (60) step(32'h0, 1'b1, 1'b1);

    chk("grant_queue_empty", exp_grant_q.size(), 0);
    chk("timeout_queue_empty", exp_tmo_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_irq_rr_scheduler.md
# bus_irq_rr_scheduler

Round-robin scheduler for the per-bus interrupt/success word collected from the 16 CAN bus channels of the MOPS-Hub. It latches each bus request as a sticky pending bit and serves them one at a time to the single downstream message handler through a valid/ready grant handshake. It holds each grant until the handler reports completion, with a watchdog timeout. It sits between the 32-bit IRQ collector word and the hub's shared CAN message handling datapath.

## Interface
- N_BUSES, 16: number of active bus request lines; bits [N_BUSES-1:0] of irq_in are used, and bits [31:N_BUSES] are ignored.
- ID_W, 5: width of grant_id.
- TIMEOUT_CYCLES, 1023: maximum BUSY cycles before forced release; the counter width is derived from it.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- irq_in  in  32  per-bus request word. A level or a one-cycle pulse sets the pending bit.
- grant_valid  out  1  a grant is offered.
- grant_id  out  ID_W  bus index of the offered or active grant.
- grant_ready  in  1  handler accepts the grant.
- done  in  1  handler finished the active grant; one-cycle pulse.
- busy  out  1  a grant has been accepted and is not yet finished.
- pending  out  32  sticky pending bits. Bits [31:N_BUSES] are always 0.
- timeout_err  out  1  one-cycle pulse when the watchdog forces a release.

## Operation
- Pending register:
  - Bit i is set on any edge where irq_in[i]=1.
  - Bit i is cleared when the grant for bus i ends, either by done or by timeout.
  - If set and clear coincide on the same bit, set wins and the bit stays 1.
- Round-robin pointer ptr (0..N_BUSES-1):
  - Search starts at ptr and wraps from N_BUSES-1 to 0.
  - After a grant of bus k ends, ptr = (k+1) mod N_BUSES.
  - Reset value of ptr is 0.
- FSM states: IDLE, OFFER, BUSY.
  - IDLE: if pending is non-zero, capture the winning index into grant_id and go to OFFER. Otherwise stay in IDLE.
  - OFFER: grant_valid=1 and grant_id is held stable. On grant_ready=1, go to BUSY and clear the watchdog. grant_valid may not drop before acceptance.
  - BUSY: busy=1 and the watchdog increments each cycle.
    - On done=1: clear pending[grant_id], advance ptr, go to IDLE.
    - Else when the watchdog reaches TIMEOUT_CYCLES: pulse timeout_err, clear pending[grant_id], advance ptr, go to IDLE.
    - If done arrives on the same cycle the watchdog expires, done wins and there is no timeout_err.
- done outside BUSY and grant_ready outside OFFER are ignored.
- New requests arriving during OFFER or BUSY only set pending bits. They never change the current grant.
- Reset values: grant_valid=0, grant_id=0, busy=0, pending=0, timeout_err=0, state IDLE.
- Reset asserted mid-grant aborts the grant immediately and drops all pending bits.

## Timing
- irq_in[i] sampled at edge k sets pending[i] after edge k.
- FSM leaves IDLE at edge k+1, so grant_valid=1 after edge k+1. Request-to-offer latency is 2 cycles.
- grant_ready sampled high at edge m gives busy=1 after edge m. grant_valid=0 after edge m.
- done sampled high at edge d gives busy=0 and the cleared pending bit after edge d.
- The next offer appears after edge d+1. There is a minimum of one IDLE cycle between grants.
- Minimum grant period is 3 cycles: OFFER, BUSY, IDLE.
- Timeout: timeout_err is high for exactly the cycle after the edge at which the counter equals TIMEOUT_CYCLES.
- All outputs are registered. There is no combinational path from any input to any output.

## Structure
- Shared package mopshub_irq_pkg holds:
  - N_BUSES_DEF=16;
  - ID_W_DEF=5;
  - the IRQ word width 32;
  - the state encoding (IDLE=2'd0, OFFER=2'd1, BUSY=2'd2).
- Sub-module rr_priority_pick: combinational round-robin finder.
  - Inputs: pending vector and ptr.
  - Outputs: found and index.
  - It is reusable by other hub arbiters.
- The top level contains the pending register, pointer, FSM and watchdog.

## Test plan
- Reset then idle: rst low then high with irq_in=0. Expect grant_valid=0, pending=0, and no activity for 50 cycles.
- Single request, default parameters:
  - Pulse irq_in=32'h0000_0020 for one cycle at edge k. Expect pending[5]=1, then grant_valid=1 with grant_id=5 after edge k+1.
  - Assert grant_ready. Expect busy=1.
  - Pulse done. Expect pending=0, and ptr advances so the next search starts at bus 6.
- Round-robin fairness: hold irq_in=32'h0000_8003 (buses 0, 1, 15) with ptr=0 and handler ready. Expect a grant order of 0, 1, 15, 0, 1, 15… with no starvation.
- Simultaneous set/clear: re-pulse irq_in[3] on the same edge as done for grant 3. Expect pending[3]=1, and bus 3 is offered again once its turn comes.
- Watchdog: accept a grant for bus 2 and never pulse done. With TIMEOUT_CYCLES=8, expect timeout_err as a single pulse after 8 BUSY cycles, busy=0 and pending[2]=0. Then check that done and the expiry on the same edge produce no timeout_err.
- Reset mid-grant and ignored inputs:
  - Assert rst during BUSY. Expect all outputs at reset values asynchronously.
  - Set irq_in[20]=1 with N_BUSES=16. Expect pending[20]=0 and no grant.
